// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 high-page responder and its
// interrupt controller.
package sm83_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [15:0] HRAM_LAST = 16'hFFFE;
  localparam logic [15:0] IF_ADDR   = 16'hFF0F;
  localparam logic [15:0] IE_ADDR   = 16'hFFFF;
  localparam int          NUM_IRQ   = 5;
  localparam int          HRAM_SIZE = 127;

  // Interrupt source index; lower index is higher priority.
  typedef enum logic [2:0] {
    VBLANK = 3'd0,
    STAT   = 3'd1,
    TIMER  = 3'd2,
    SERIAL = 3'd3,
    JOYPAD = 3'd4
  } irq_idx_e;

endpackage

// File: rtl/sm83_irq_ctrl.sv
// Interrupt flag / enable registers, rising-edge request latching,
// lowest-index-first priority encoder and dispatch acknowledge clear.
module sm83_irq_ctrl #(
  parameter int NUM_IRQ = sm83_pkg::NUM_IRQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               if_we,
  input  logic               ie_we,
  input  logic [7:0]         wdata,
  input  logic               int_ack,
  output logic [NUM_IRQ-1:0] if_q,
  output logic [7:0]         ie_q,
  output logic               irq,
  output logic [2:0]         int_num
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] if_d;

  assign rise    = irq_src & ~irq_q;
  assign pending = ie_q[NUM_IRQ-1:0] & if_q;
  assign irq     = |pending;

  // Lowest pending index wins; 0 when nothing is pending.
  always_comb begin
    int_num = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) int_num = 3'(i);
    end
  end

  // Next IF: ack clear is overridden by a CPU write, which is overridden
  // by a fresh rising edge, so a request is never lost to a same-cycle write.
  always_comb begin
    if_d = if_q;
    if (int_ack && irq) if_d[int_num] = 1'b0;
    if (if_we) if_d = wdata[NUM_IRQ-1:0];
    if_d = if_d | rise;
  end

  // Register IF, IE and the source sample used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q  <= '0;
      ie_q  <= '0;
      irq_q <= '0;
    end else begin
      if_q  <= if_d;
      irq_q <= irq_src;
      if (ie_we) ie_q <= wdata;
    end
  end

endmodule

// File: rtl/sm83_hipage_resp.sv
// High-page bus responder: HRAM (FF80-FFFE), IF (FF0F) and IE (FFFF),
// with read data captured at T2 and writes committed at T3.
module sm83_hipage_resp #(
  parameter logic [15:0] HRAM_BASE = sm83_pkg::HRAM_BASE,
  parameter logic [15:0] IF_ADDR   = sm83_pkg::IF_ADDR,
  parameter logic [15:0] IE_ADDR   = sm83_pkg::IE_ADDR,
  parameter int          NUM_IRQ   = sm83_pkg::NUM_IRQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t1,
  input  logic               t2,
  input  logic               t3,
  input  logic               t4,
  input  logic [15:0]        addr,
  input  logic               rd,
  input  logic               wr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               hit,
  output logic [7:0]         iena,
  output logic               iena_sel,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq,
  output logic [2:0]         int_num,
  input  logic               int_ack
);

  import sm83_pkg::*;

  logic               hram_hit;
  logic               if_hit;
  logic               ie_hit;
  logic [6:0]         hram_idx;
  logic               abort_q;
  logic               wr_ok;
  byte_t              rd_val;
  byte_t              rdata_r;
  logic [NUM_IRQ-1:0] if_q;
  byte_t              ie_q;

  // HRAM contents survive reset; the initializer only gives simulation a
  // defined starting image.
  byte_t mem [HRAM_SIZE] = '{default: '0};

  assign hram_hit = (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  assign if_hit   = (addr == IF_ADDR);
  assign ie_hit   = (addr == IE_ADDR);
  assign hit      = hram_hit | if_hit | ie_hit;
  assign hram_idx = 7'(addr - HRAM_BASE);

  assign iena     = ie_q;
  assign iena_sel = rd && ie_hit;
  assign rdata    = rdata_r;

  // A write is only allowed if reset has not hit the current M-cycle.
  assign wr_ok = wr && t3 && !abort_q;

  // Remember that reset interrupted an M-cycle until the next phase
  // boundary (T4 end or T1) proves a fresh cycle has started.
  always_ff @(posedge clk) begin
    if (reset) abort_q <= 1'b1;
    else if (t1 || t4) abort_q <= 1'b0;
  end

  // HRAM byte write at T3.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && hram_hit) mem[hram_idx] <= wdata;
  end

  // Read mux; unmapped addresses float high like an idle bus.
  always_comb begin
    rd_val = 8'hFF;
    if (hram_hit)    rd_val = mem[hram_idx];
    else if (if_hit) rd_val = {{(8 - NUM_IRQ){1'b1}}, if_q};
    else if (ie_hit) rd_val = ie_q;
  end

  // Capture read data at T2 and hold it; a colliding write suppresses the read.
  always_ff @(posedge clk) begin
    if (reset) rdata_r <= 8'hFF;
    else if (rd && t2 && !wr) rdata_r <= rd_val;
  end

  sm83_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq_ctrl (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .if_we   (wr_ok && if_hit),
    .ie_we   (wr_ok && ie_hit),
    .wdata   (wdata),
    .int_ack (int_ack),
    .if_q    (if_q),
    .ie_q    (ie_q),
    .irq     (irq),
    .int_num (int_num)
  );

endmodule

// File: tb/tb_sm83_hipage_resp.sv
// Self-checking bench for sm83_hipage_resp: directed scenarios followed by
// random M-cycles checked against a behavioural reference model.
module tb_sm83_hipage_resp;

  logic        clk;
  logic        reset;
  logic        t1, t2, t3, t4;
  logic [15:0] addr;
  logic        rd, wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hit;
  logic [7:0]  iena;
  logic        iena_sel;
  logic [4:0]  irq_src;
  logic        irq;
  logic [2:0]  int_num;
  logic        int_ack;

  int errors = 0;
  int checks = 0;

  sm83_hipage_resp dut (
    .clk      (clk),
    .reset    (reset),
    .t1       (t1),
    .t2       (t2),
    .t3       (t3),
    .t4       (t4),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .iena     (iena),
    .iena_sel (iena_sel),
    .irq_src  (irq_src),
    .irq      (irq),
    .int_num  (int_num),
    .int_ack  (int_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [127];
  logic [7:0] m_ie;
  logic [4:0] m_if;
  logic [4:0] m_src_prev;
  logic [7:0] m_rdata;
  logic       m_abort;

  initial for (int i = 0; i < 127; i++) m_mem[i] = 8'h00;

  function automatic logic [2:0] m_int_num();
    for (int i = 0; i < 5; i++)
      if (m_ie[i] && m_if[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic m_irq();
    return ((m_ie[4:0] & m_if) != 5'd0);
  endfunction

  function automatic logic in_hram(input logic [15:0] a);
    return (a >= 16'hFF80) && (a != 16'hFFFF);
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] nif;
    logic       wok;
    if (reset) begin
      m_ie = 8'h00; m_if = 5'd0; m_src_prev = 5'd0; m_rdata = 8'hFF; m_abort = 1'b1;
    end else begin
      if (rd && t2 && !wr) begin
        if (in_hram(addr))          m_rdata = m_mem[addr - 16'hFF80];
        else if (addr == 16'hFF0F)  m_rdata = 8'hE0 + {3'b000, m_if};
        else if (addr == 16'hFFFF)  m_rdata = m_ie;
        else                        m_rdata = 8'hFF;
      end
      wok = wr && t3 && !m_abort;
      nif = m_if;
      if (int_ack && m_irq()) nif[m_int_num()] = 1'b0;
      if (wok && addr == 16'hFF0F) nif = wdata[4:0];
      nif = nif | (irq_src & ~m_src_prev);
      if (wok && addr == 16'hFFFF) m_ie = wdata;
      if (wok && in_hram(addr)) m_mem[addr - 16'hFF80] = wdata;
      m_if = nif;
      m_src_prev = irq_src;
      if (t1 || t4) m_abort = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic mcycle(input logic do_rd, input logic do_wr, input logic [15:0] a,
                        input logic [7:0] d, input int ack_ph, input int src_ph,
                        input logic [4:0] src_v);
    for (int ph = 1; ph <= 4; ph++) begin
      @(negedge clk);
      t1 = (ph == 1); t2 = (ph == 2); t3 = (ph == 3); t4 = (ph == 4);
      rd = do_rd; wr = do_wr; addr = a; wdata = d;
      int_ack = (ph == ack_ph);
      if (ph == src_ph) irq_src = src_v;
    end
    #1;
  endtask

  task automatic wr_cyc(input logic [15:0] a, input logic [7:0] d);
    mcycle(1'b0, 1'b1, a, d, 0, 0, 5'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    mcycle(1'b1, 1'b0, a, 8'h00, 0, 0, 5'd0);
    chk(tag, 16'(rdata), 16'(exp));
  endtask

  task automatic idle(input int ack_ph, input int src_ph, input logic [4:0] src_v);
    mcycle(1'b0, 1'b0, 16'h0000, 8'h00, ack_ph, src_ph, src_v);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        r, w;
    int          k, op;

    reset = 1'b1; t1 = 0; t2 = 0; t3 = 0; t4 = 0;
    addr = 16'h0000; rd = 0; wr = 0; wdata = 8'h00; irq_src = 5'd0; int_ack = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdata", 16'(rdata), 16'h00FF);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_int_num", 16'(int_num), 16'h0);
    chk("rst_iena", 16'(iena), 16'h00);
    chk("rst_hit", 16'(hit), 16'h0);

    // HRAM write then read-after-write
    wr_cyc(16'hFF80, 8'h5A);
    rd_chk("hram_raw", 16'hFF80, 8'h5A);
    chk("hram_hit", 16'(hit), 16'h1);

    // unmapped read/write
    rd_chk("unmapped_rd", 16'hC000, 8'hFF);
    chk("unmapped_hit", 16'(hit), 16'h0);
    wr_cyc(16'hC000, 8'hAA);
    rd_chk("hram_kept", 16'hFF80, 8'h5A);

    // single timer interrupt
    wr_cyc(16'hFFFF, 8'h05);
    idle(0, 1, 5'b00100);
    idle(0, 1, 5'b00000);
    chk("timer_irq", 16'(irq), 16'h1);
    chk("timer_num", 16'(int_num), 16'(sm83_pkg::TIMER));
    rd_chk("if_read", 16'hFF0F, 8'hE4);
    rd_chk("ie_read", 16'hFFFF, 8'h05);
    chk("iena_sel", 16'(iena_sel), 16'h1);
    chk("iena", 16'(iena), 16'h05);

    // priority and ack
    wr_cyc(16'hFFFF, 8'h1F);
    wr_cyc(16'hFF0F, 8'h05);
    chk("prio_num0", 16'(int_num), 16'(sm83_pkg::VBLANK));
    idle(2, 0, 5'd0);
    rd_chk("ack1_if", 16'hFF0F, 8'hE4);
    chk("ack1_num", 16'(int_num), 16'h2);
    idle(2, 0, 5'd0);
    rd_chk("ack2_if", 16'hFF0F, 8'hE0);
    chk("ack2_irq", 16'(irq), 16'h0);
    idle(2, 0, 5'd0);
    rd_chk("ack_noop_if", 16'hFF0F, 8'hE0);

    // edge beats a same-cycle clearing write
    mcycle(1'b0, 1'b1, 16'hFF0F, 8'h00, 0, 3, 5'b00010);
    rd_chk("edge_vs_wr", 16'hFF0F, 8'hE2);
    chk("edge_num", 16'(int_num), 16'(sm83_pkg::STAT));
    wr_cyc(16'hFF0F, 8'h00);
    rd_chk("level_no_reset", 16'hFF0F, 8'hE0);
    idle(0, 1, 5'd0);

    // reset during T2 of an IE write aborts it
    wr_cyc(16'hFF0F, 8'h01);
    chk("pre_rst_irq", 16'(irq), 16'h1);
    @(negedge clk); t1 = 1; t2 = 0; t3 = 0; t4 = 0; rd = 0; wr = 1; addr = 16'hFFFF; wdata = 8'hFF;
    @(negedge clk); t1 = 0; t2 = 1; reset = 1'b1;
    @(negedge clk); t2 = 0; t3 = 1; reset = 1'b0;
    @(negedge clk); t3 = 0; t4 = 1;
    #1;
    chk("abort_iena", 16'(iena), 16'h00);
    chk("abort_rdata", 16'(rdata), 16'h00FF);
    chk("abort_irq", 16'(irq), 16'h0);
    rd_chk("abort_ie_rd", 16'hFFFF, 8'h00);
    rd_chk("hram_after_rst", 16'hFF80, 8'h5A);

    // random M-cycles against the model
    for (k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 16'hFF80 + 16'($urandom_range(0, 126));
        5:             a = 16'hFF0F;
        6:             a = 16'hFFFF;
        7:             a = 16'hFF7F;
        8:             a = 16'($urandom);
        default:       a = 16'hFFFE;
      endcase
      d = 8'($urandom);
      r = (op <= 3) || (op == 9);
      w = (op >= 4 && op <= 6) || (op == 9);
      mcycle(r, w, a, d,
             ($urandom_range(0, 3) == 0) ? 4 : 0,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
             5'($urandom));
      chk("rnd_rdata", 16'(rdata), 16'(m_rdata));
      chk("rnd_hit", 16'(hit), 16'((a >= 16'hFF80) || (a == 16'hFF0F)));
      chk("rnd_iena_sel", 16'(iena_sel), 16'(r && a == 16'hFFFF));
      chk("rnd_iena", 16'(iena), 16'(m_ie));
      chk("rnd_irq", 16'(irq), 16'(m_irq()));
      chk("rnd_int_num", 16'(int_num), 16'(m_int_num()));
    end

    idle(0, 0, 5'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
